// File: rtl/ntt_pkg.sv
// Shared NTT datapath defaults and the pointwise-multiply FSM state encoding.
// Used by the NTT stages as well as the pointwise multiplier.
package ntt_pkg;

   localparam int unsigned DEF_Q    = 17;
   localparam int unsigned DEF_N    = 8;
   localparam int unsigned DEF_LOGQ = 5;
   localparam int unsigned DEF_LOGN = 3;

   typedef enum logic {
      LOAD = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply: result = (x*y) mod q, product kept at full width.
// Shared with the NTT butterfly.
module mod_mul
   import ntt_pkg::*;
#(
   parameter int unsigned q    = DEF_Q,
   parameter int unsigned logq = DEF_LOGQ
) (
   input  logic [logq-1:0] x,
   input  logic [logq-1:0] y,
   output logic [logq-1:0] result
);

   logic [2*logq-1:0] prod;

   assign prod   = (2*logq)'(x) * (2*logq)'(y);
   assign result = logq'(prod % (2*logq)'(q));

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise product of two NTT-domain polynomials: buffer A in LOAD, then
// stream B against it in MUL, emitting (A[k]*B[k]) mod q through a one-entry output stage.
module ntt_pointwise_mul
   import ntt_pkg::*;
#(
   parameter int unsigned q    = DEF_Q,
   parameter int unsigned N    = DEF_N,
   parameter int unsigned logq = DEF_LOGQ,
   parameter int unsigned logN = DEF_LOGN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            a_valid,
   input  logic [logq-1:0] a_data,
   output logic            a_ready,
   input  logic            b_valid,
   input  logic [logq-1:0] b_data,
   output logic            b_ready,
   output logic            out_valid,
   output logic [logq-1:0] out_data,
   input  logic            out_ready
);

   localparam logic [logN-1:0] A_LAST = logN'(N - 1);
   localparam logic [logN:0]   B_END  = (logN + 1)'(N);
   localparam logic [logN:0]   O_LAST = (logN + 1)'(N - 1);

   state_t          state, state_next;
   logic [logq-1:0] coef_buf [N];
   logic [logN-1:0] a_cnt;
   logic [logN:0]   b_cnt;
   logic [logN:0]   out_cnt;
   logic [logq-1:0] product;
   logic            a_fire, b_fire, out_fire;

   assign a_fire   = a_valid && a_ready;
   assign b_fire   = b_valid && b_ready;
   assign out_fire = out_valid && out_ready;

   mod_mul #(.q(q), .logq(logq)) u_mod_mul (
      .x      (coef_buf[b_cnt[logN-1:0]]),
      .y      (b_data),
      .result (product)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= LOAD;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      unique case (state)
         LOAD: begin
            a_ready = 1'b1;
            if (a_valid && a_cnt == A_LAST) state_next = MUL;
         end
         MUL: begin
            b_ready = (b_cnt < B_END) && (!out_valid || out_ready);
            if (out_fire && out_cnt == O_LAST) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   // Coefficient store is deliberately unreset; every LOAD rewrites all N entries.
   always_ff @(posedge clk) begin
      if (a_fire) coef_buf[a_cnt] <= a_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_cnt     <= '0;
         b_cnt     <= '0;
         out_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (a_fire) a_cnt <= (a_cnt == A_LAST) ? '0 : a_cnt + 1'b1;

         // A new product overwrites the register even while the old one drains (no bubble).
         if (b_fire) begin
            out_data  <= product;
            out_valid <= 1'b1;
            b_cnt     <= b_cnt + 1'b1;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end

         // The final output never coincides with a B transfer, since b_cnt has reached N.
         if (out_fire) begin
            if (out_cnt == O_LAST) begin
               out_cnt <= '0;
               b_cnt   <= '0;
            end else begin
               out_cnt <= out_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Self-checking bench for ntt_pointwise_mul: a queue of expected products per
// polynomial pair, with randomized handshakes and literal reference sequences.
module tb_ntt_pointwise_mul;

   localparam int QV = 17;
   localparam int NV = 8;
   localparam int LQ = 5;
   localparam int LN = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          a_valid, b_valid, out_ready;
   logic [LQ-1:0] a_data, b_data;
   logic          a_ready, b_ready, out_valid;
   logic [LQ-1:0] out_data;

   ntt_pointwise_mul #(.q(QV), .N(NV), .logq(LQ), .logN(LN)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int exp_q[$];
   int obs_q[$];
   int or_mode = 0;   // 0: always ready, 1: random, 2: stalled
   int A[NV];
   int B[NV];
   bit stop_noise;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 9) < 7);
         default: out_ready = 1'b0;
      endcase
   end

   // Single compare process: every output transfer against the model queue, plus hold stability.
   logic          prev_ov = 1'b0, prev_or = 1'b0;
   logic [LQ-1:0] prev_d = '0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_ov = 1'b0;
      end else begin
         if (prev_ov && !prev_or) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), int'(prev_d));
         end
         if (out_valid && out_ready) begin
            check("out_lt_q", int'(out_data < LQ'(QV)), 1);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %0d expected none at %0t", out_data, $time);
            end else begin
               check("product", int'(out_data), exp_q.pop_front());
               obs_q.push_back(int'(out_data));
            end
         end
         prev_ov = out_valid;
         prev_or = out_ready;
         prev_d  = out_data;
      end
   end

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer_a(input int d);
      int t = 0;
      a_valid = 1'b1;
      a_data  = LQ'(d);
      @(negedge clk);
      while (!a_ready) begin
         t++;
         if (t > 200) begin
            check("a_ready_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
   endtask

   task automatic xfer_b(input int d);
      int t = 0;
      b_valid = 1'b1;
      b_data  = LQ'(d);
      @(negedge clk);
      while (!b_ready) begin
         t++;
         if (t > 200) begin
            check("b_ready_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      b_valid = 1'b0;
   endtask

   task automatic push_exp();
      for (int k = 0; k < NV; k++) exp_q.push_back((A[k] * B[k]) % QV);
   endtask

   task automatic rand_pair();
      for (int k = 0; k < NV; k++) begin
         A[k] = $urandom_range(0, 31);
         B[k] = $urandom_range(0, 31);
      end
   endtask

   task automatic load_a(input bit gaps);
      for (int k = 0; k < NV; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) realign();
         xfer_a(A[k]);
      end
   endtask

   task automatic feed_b(input int first, input int last, input bit gaps);
      for (int k = first; k <= last; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) realign();
         xfer_b(B[k]);
      end
   endtask

   task automatic drain_check(input string name);
      int t = 0;
      @(negedge clk);
      #1;
      while (exp_q.size() != 0 && t < 300) begin
         t++;
         @(negedge clk);
         #1;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      @(posedge clk);
      @(negedge clk);
      check({name, "_a_ready_after"}, int'(a_ready), 1);
      realign();
   endtask

   task automatic check_literal(input string name, input int lit[NV]);
      check({name, "_count"}, obs_q.size(), NV);
      for (int k = 0; k < NV && k < obs_q.size(); k++) check(name, obs_q[k], lit[k]);
   endtask

   task automatic contiguous_pair();
      rand_pair();
      push_exp();
      load_a(1'b0);
      fork
         feed_b(0, NV - 1, 1'b0);
         begin
            int cnt = 0;
            int t = 0;
            @(negedge clk);
            while (!out_valid && t < 50) begin
               t++;
               @(negedge clk);
            end
            while (out_valid && cnt < 20) begin
               cnt++;
               @(negedge clk);
            end
            check("contig_valid", cnt, NV);
            check("contig_a_ready", int'(a_ready), 1);
         end
      join
      realign();
   endtask

   int lit_033[NV] = '{3, 6, 9, 12, 15, 1, 4, 7};
   int lit_ones[NV] = '{1, 1, 1, 1, 1, 1, 1, 1};

   initial begin
      reset_n = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_data  = '0;
      b_data  = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_ready", int'(a_ready), 1);
      check("rst_b_ready", int'(b_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      reset_n = 1'b1;
      realign();

      // A=1..8, B=3: literal sequence and one-cycle latency
      for (int k = 0; k < NV; k++) begin A[k] = k + 1; B[k] = 3; end
      push_exp();
      obs_q.delete();
      load_a(1'b0);
      check("mul_a_ready_low", int'(a_ready), 0);
      xfer_b(B[0]);
      @(negedge clk);
      check("latency_valid", int'(out_valid), 1);
      check("latency_data", int'(out_data), 3);
      realign();
      feed_b(1, NV - 1, 1'b0);
      drain_check("basic");
      check_literal("basic_seq", lit_033);

      // Maximal operands
      for (int k = 0; k < NV; k++) begin A[k] = 16; B[k] = 16; end
      push_exp();
      obs_q.delete();
      load_a(1'b1);
      feed_b(0, NV - 1, 1'b1);
      drain_check("max");
      check_literal("max_seq", lit_ones);

      // Output stall mid-stream
      rand_pair();
      push_exp();
      load_a(1'b0);
      fork
         feed_b(0, NV - 1, 1'b0);
         begin
            repeat (3) @(posedge clk);
            or_mode = 2;
            repeat (6) begin
               @(negedge clk);
               if (out_valid && !out_ready) check("b_ready_stall", int'(b_ready), 0);
            end
            or_mode = 0;
         end
      join
      realign();
      drain_check("stall");

      // A noise during MUL must be ignored
      for (int k = 0; k < NV; k++) begin A[k] = k + 1; B[k] = 3; end
      push_exp();
      obs_q.delete();
      load_a(1'b0);
      stop_noise = 1'b0;
      fork
         begin
            feed_b(0, NV - 1, 1'b1);
            stop_noise = 1'b1;
         end
         begin
            while (!stop_noise) begin
               @(posedge clk);
               #1;
               a_valid = 1'b1;
               a_data  = LQ'($urandom_range(0, 31));
               @(negedge clk);
               check("a_ready_in_mul", int'(a_ready), 0);
            end
            a_valid = 1'b0;
         end
      join
      realign();
      drain_check("noise");
      check_literal("noise_seq", lit_033);

      // Reset after the 4th B transfer
      for (int k = 0; k < NV; k++) begin A[k] = k + 1; B[k] = 3; end
      push_exp();
      load_a(1'b0);
      feed_b(0, 3, 1'b0);
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_a_ready", int'(a_ready), 1);
      check("midrst_b_ready", int'(b_ready), 0);
      exp_q.delete();
      realign();
      reset_n = 1'b1;
      realign();
      rand_pair();
      push_exp();
      load_a(1'b0);
      feed_b(0, NV - 1, 1'b0);
      drain_check("post_rst");

      // Randomized pairs with random gaps and backpressure
      or_mode = 1;
      for (int p = 0; p < 6; p++) begin
         rand_pair();
         push_exp();
         load_a(1'b1);
         feed_b(0, NV - 1, 1'b1);
         drain_check("rand");
      end
      or_mode = 0;
      realign();

      // Back-to-back pairs at full rate
      contiguous_pair();
      contiguous_pair();
      drain_check("b2b");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ntt_pointwise_mul.md
NTT_POINTWISE_MUL -- requirements
Module: ntt_pointwise_mul

Interface
REQ-001 SHALL have parameter q, default 17, meaning NTT modulus.
REQ-002 SHALL have parameter N, default 8, meaning coefficients per polynomial.
REQ-003 SHALL have parameter logq, default 5, meaning coefficient width in bits.
REQ-004 SHALL have parameter logN, default 3, meaning log2(N) and counter width.
REQ-005 SHALL have port clk, input, 1 bit, meaning clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have port a_valid, input, 1 bit, meaning an operand-A coefficient is present (from NTT stage A).
REQ-008 SHALL have port a_data, input, logq bits, meaning the operand-A coefficient.
REQ-009 SHALL have port a_ready, output, 1 bit, meaning the block accepts A this cycle.
REQ-010 SHALL have port b_valid, input, 1 bit, meaning an operand-B coefficient is present (from NTT stage B).
REQ-011 SHALL have port b_data, input, logq bits, meaning the operand-B coefficient.
REQ-012 SHALL have port b_ready, output, 1 bit, meaning the block accepts B this cycle.
REQ-013 SHALL have port out_valid, output, 1 bit, meaning out_data holds a valid product.
REQ-014 SHALL have port out_data, output, logq bits, meaning (A[k]*B[k]) mod q.
REQ-015 SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts out_data.

Function
REQ-016 SHALL be a two-state FSM: LOAD (buffer A) and MUL (stream B, emit products).
REQ-017 Transfers SHALL occur only on a cycle where valid and ready are both high at the rising edge.
REQ-018 In LOAD: a_ready=1, b_ready=0; each A transfer writes buf[a_cnt] and increments a_cnt.
REQ-019 On the A transfer with a_cnt==N-1: a_cnt SHALL wrap to 0 and the FSM SHALL enter MUL on the next cycle.
REQ-020 In MUL: a_ready=0; a_valid SHALL be ignored and buf SHALL NOT change.
REQ-021 In MUL: b_ready SHALL equal (b_cnt<N) && (!out_valid || out_ready), giving single-entry output buffering with pass-through.
REQ-022 On a B transfer: out_data<=(buf[b_cnt]*b_data) mod q and out_valid<=1 at the next edge, giving 1-cycle latency, and b_cnt SHALL increment.
REQ-023 The product SHALL be computed at full 2*logq width before reduction; the result SHALL be <q for any input values.
REQ-024 When out_valid=1 and out_ready=0: out_data and out_valid SHALL hold stable.
REQ-025 When an output transfer and a B transfer occur in the same cycle: the new product SHALL replace out_data with no bubble.
REQ-026 When an output transfer occurs and no B transfer occurs in that cycle: out_valid SHALL fall.
REQ-027 On the output transfer of the N-th product: b_cnt and out_cnt SHALL clear and the FSM SHALL return to LOAD with a_ready=1 on the next cycle.
REQ-028 Sustained throughput SHALL be 1 coefficient/cycle in both LOAD and MUL.

Reset
REQ-029 On reset_n low: state=LOAD, a_cnt=b_cnt=out_cnt=0, out_valid=0, out_data=0, and therefore a_ready=1, b_ready=0.
REQ-030 Reset asserted mid-LOAD or mid-MUL SHALL abort the current polynomial; buf contents are not reset and SHALL be overwritten by the next LOAD.

Structure
REQ-031 Parameters q/N/logq/logN defaults and the LOAD/MUL state encodings SHALL live in shared package ntt_pkg, which is also used by the ntt stages.
REQ-032 Modular multiply SHALL be a combinational sub-module mod_mul (inputs x, y; output (x*y) mod q), reusable by the NTT butterfly.

Verification (q=17, N=8)
REQ-033 A=1..8, B all 3, out_ready=1 -> out 3,6,9,12,15,1,4,7; product 1 out one cycle after first B transfer; a_ready=1 after the 8th output.
REQ-034 A all 16, B all 16 -> every output 1 (256 mod 17), never >=17.
REQ-035 out_ready held 0 for 5 cycles mid-stream -> out_data stable, b_ready=0, no B lost or duplicated, order preserved.
REQ-036 a_valid=1 with random a_data throughout MUL -> a_ready=0, products unchanged versus REQ-033.
REQ-037 reset_n pulsed low after 4th B transfer -> out_valid=0 immediately, a_ready=1; then a fresh polynomial pair yields correct products.
REQ-038 Back-to-back pairs of polynomials with b_valid and out_ready always 1 -> 8 contiguous out_valid cycles per pair, LOAD restarted after each.
